// File: rtl/requant_pack_pkg.sv
// Shared widths and the output FIFO entry format for the requantise-and-pack block.
package requant_pack_pkg;

  localparam int ACC_W      = 32;
  localparam int MULT_W     = 16;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;
  localparam int PROD_W     = ACC_W + MULT_W + 1;
  localparam int NB_W       = 3;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [NB_W-1:0]   nbytes;
    logic              last;
  } fifo_entry_t;

endpackage

// File: rtl/requant_fifo.sv
// First-word-fall-through FIFO of packed output words; head reads as zero while empty.
module requant_fifo
  import requant_pack_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t dout,
  output logic        empty,
  output logic [AW:0] free
);

  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  fifo_entry_t mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, count;
  logic        full, do_push, do_pop;

  always_comb begin
    count   = wr_q - rd_q;
    empty   = (count == '0);
    full    = (count == DEPTH_V);
    free    = DEPTH_V - count;
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    dout    = empty ? '0 : mem[rd_q[AW-1:0]];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/requant_pack.sv
// Requantises conv accumulators to bytes (multiply, round-shift, clamp) and packs
// them four to a word into an output FIFO, closing each image with a last word.
module requant_pack
  import requant_pack_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [ACC_W-1:0] result,
  input  logic                    resultValid,
  input  logic                    imageDone,
  output logic                    out_accepting_values,
  input  logic                    cfg_valid,
  input  logic [MULT_W-1:0]       cfg_mult,
  input  logic [4:0]              cfg_shift,
  input  logic [BYTE_W-1:0]       cfg_max,
  input  logic                    out_rd_en,
  output logic [WORD_W-1:0]       out_dout,
  output logic [NB_W-1:0]         out_nbytes,
  output logic                    out_last,
  output logic                    out_empty,
  output logic                    busy,
  output logic                    overflow_err
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FREE_MIN = (AW + 1)'(3);

  function automatic logic signed [PROD_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] p,
    input logic [4:0]               sh
  );
    logic signed [PROD_W-1:0] bias;
    bias = '0;
    if (sh != 5'd0) bias[sh - 5'd1] = 1'b1;
    return (p + bias) >>> sh;
  endfunction

  function automatic logic [BYTE_W-1:0] clamp_byte(
    input logic signed [PROD_W-1:0] q,
    input logic [BYTE_W-1:0]        mx
  );
    logic signed [PROD_W-1:0] lim;
    lim = $signed({{(PROD_W-BYTE_W){1'b0}}, mx});
    if (q[PROD_W-1])  return '0;
    else if (q > lim) return mx;
    else              return q[BYTE_W-1:0];
  endfunction

  logic [MULT_W-1:0] cfg_mult_q, cfg_mult_d;
  logic [4:0]        cfg_shift_q, cfg_shift_d;
  logic [BYTE_W-1:0] cfg_max_q, cfg_max_d;
  logic              ovf_q, ovf_d;

  logic acc_in, done_in;
  logic vld_p1_q, vld_p1_d, done_p1_q, done_p1_d;
  logic vld_p2_q, vld_p2_d, done_p2_q, done_p2_d;
  logic vld_p3_q, vld_p3_d, done_p3_q, done_p3_d;

  logic signed [PROD_W-1:0] prod_p1_q, prod_p1_d;
  logic signed [PROD_W-1:0] q_p2_q, q_p2_d;
  logic [BYTE_W-1:0]        byte_p3_q, byte_p3_d;
  logic signed [PROD_W-1:0] a_ext, m_ext;

  logic [WORD_BYTES-1:0][BYTE_W-1:0] word_q, word_d;
  logic [NB_W-1:0]                   cnt_q, cnt_d, cnt_n;
  logic                              push;
  fifo_entry_t                       push_entry, head;
  logic                              fifo_empty;
  logic [AW:0]                       fifo_free;

  assign acc_in  = resultValid & out_accepting_values;
  assign done_in = imageDone & out_accepting_values;

  always_comb begin
    cfg_mult_d  = cfg_mult_q;
    cfg_shift_d = cfg_shift_q;
    cfg_max_d   = cfg_max_q;
    if (cfg_valid && !busy) begin
      cfg_mult_d  = cfg_mult;
      cfg_shift_d = cfg_shift;
      cfg_max_d   = cfg_max;
    end
    ovf_d = ovf_q | ((resultValid | imageDone) & ~out_accepting_values);
  end

  // Stage 1: widen and multiply
  always_comb begin
    a_ext     = {{(PROD_W-ACC_W){result[ACC_W-1]}}, result};
    m_ext     = $signed({{(PROD_W-MULT_W){1'b0}}, cfg_mult_q});
    vld_p1_d  = acc_in;
    done_p1_d = done_in;
    prod_p1_d = acc_in ? a_ext * m_ext : prod_p1_q;
  end

  // Stage 2: round-half-up arithmetic shift
  always_comb begin
    vld_p2_d  = vld_p1_q;
    done_p2_d = done_p1_q;
    q_p2_d    = vld_p1_q ? round_shift(prod_p1_q, cfg_shift_q) : q_p2_q;
  end

  // Stage 3: clamp to [0, cfg_max]
  always_comb begin
    vld_p3_d  = vld_p2_q;
    done_p3_d = done_p2_q;
    byte_p3_d = vld_p2_q ? clamp_byte(q_p2_q, cfg_max_q) : byte_p3_q;
  end

  // Packer: a done token closes the word even when it just filled up, so no empty word follows
  always_comb begin
    word_d     = word_q;
    cnt_n      = cnt_q;
    push       = 1'b0;
    push_entry = '0;
    if (vld_p3_q) begin
      word_d[cnt_q[1:0]] = byte_p3_q;
      cnt_n              = cnt_q + 3'd1;
    end
    cnt_d = cnt_n;
    if (done_p3_q || cnt_n == 3'd4) begin
      push  = 1'b1;
      cnt_d = '0;
      for (int i = 0; i < WORD_BYTES; i++)
        push_entry.data[i*BYTE_W +: BYTE_W] = (3'(i) < cnt_n) ? word_d[i] : '0;
      push_entry.nbytes = cnt_n;
      push_entry.last   = done_p3_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cfg_mult_q  <= MULT_W'(1);
      cfg_shift_q <= '0;
      cfg_max_q   <= '1;
      ovf_q       <= 1'b0;
      vld_p1_q    <= 1'b0;
      done_p1_q   <= 1'b0;
      vld_p2_q    <= 1'b0;
      done_p2_q   <= 1'b0;
      vld_p3_q    <= 1'b0;
      done_p3_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      cfg_mult_q  <= cfg_mult_d;
      cfg_shift_q <= cfg_shift_d;
      cfg_max_q   <= cfg_max_d;
      ovf_q       <= ovf_d;
      vld_p1_q    <= vld_p1_d;
      done_p1_q   <= done_p1_d;
      vld_p2_q    <= vld_p2_d;
      done_p2_q   <= done_p2_d;
      vld_p3_q    <= vld_p3_d;
      done_p3_q   <= done_p3_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    prod_p1_q <= prod_p1_d;
    q_p2_q    <= q_p2_d;
    byte_p3_q <= byte_p3_d;
    word_q    <= word_d;
  end

  requant_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (out_rd_en),
    .dout  (head),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

  assign out_accepting_values = (fifo_free >= FREE_MIN);
  assign out_dout             = head.data;
  assign out_nbytes           = head.nbytes;
  assign out_last             = head.last;
  assign out_empty            = fifo_empty;
  assign overflow_err         = ovf_q;
  assign busy                 = vld_p1_q | done_p1_q | vld_p2_q | done_p2_q |
                                vld_p3_q | done_p3_q | (cnt_q != '0) | ~fifo_empty;

endmodule

// File: tb/tb_requant_pack.sv
// Directed bench for requant_pack: expected words queued at stimulus time, popped by a monitor.
module tb_requant_pack;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic signed [31:0] result = '0;
  logic               resultValid = 1'b0;
  logic               imageDone = 1'b0;
  logic               out_accepting_values;
  logic               cfg_valid = 1'b0;
  logic [15:0]        cfg_mult = '0;
  logic [4:0]         cfg_shift = '0;
  logic [7:0]         cfg_max = '0;
  logic               out_rd_en = 1'b0;
  logic [31:0]        out_dout;
  logic [2:0]         out_nbytes;
  logic               out_last;
  logic               out_empty;
  logic               busy;
  logic               overflow_err;

  int          checks = 0;
  int          errors = 0;
  bit          auto_pop = 1'b0;
  logic [35:0] exp_q[$];
  string       tname = "reset";

  requant_pack #(.FIFO_DEPTH(4)) dut (
    .clock                (clock),
    .reset                (reset),
    .result               (result),
    .resultValid          (resultValid),
    .imageDone            (imageDone),
    .out_accepting_values (out_accepting_values),
    .cfg_valid            (cfg_valid),
    .cfg_mult             (cfg_mult),
    .cfg_shift            (cfg_shift),
    .cfg_max              (cfg_max),
    .out_rd_en            (out_rd_en),
    .out_dout             (out_dout),
    .out_nbytes           (out_nbytes),
    .out_last             (out_last),
    .out_empty            (out_empty),
    .busy                 (busy),
    .overflow_err         (overflow_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  // Monitor: compare FIFO head against the scoreboard and pop it
  initial begin
    forever begin
      @(negedge clock);
      if (auto_pop && !out_empty) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_unexpected actual=%h/%0d/%0d expected=none", tname, out_dout, out_nbytes, out_last);
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          if ({out_dout, out_nbytes, out_last} !== e) begin
            errors++;
            $display("FAIL %s_word actual=%h/%0d/%0d expected=%h/%0d/%0d",
                     tname, out_dout, out_nbytes, out_last, e[35:4], e[3:1], e[0]);
          end
        end
        out_rd_en = 1'b1;
      end else begin
        out_rd_en = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic signed [31:0] v, input logic dn);
    result = v; resultValid = 1'b1; imageDone = dn;
    tick();
    resultValid = 1'b0; imageDone = 1'b0;
  endtask

  task automatic send_done();
    imageDone = 1'b1;
    tick();
    imageDone = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [2:0] nb, input logic lst);
    exp_q.push_back({d, nb, lst});
  endtask

  task automatic set_cfg(input logic [15:0] m, input logic [4:0] s, input logic [7:0] mx);
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    chk({tname, "_cfg_idle"}, busy, 0);
    cfg_mult = m; cfg_shift = s; cfg_max = mx; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic drain(input bit need_idle);
    int n = 0;
    while (!(exp_q.size() == 0 && out_empty && (!need_idle || !busy)) && n < 100) begin
      tick(); n++;
    end
    chk({tname, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int n_acc;
    tick(); tick();
    chk("reset_accept", out_accepting_values, 1);
    chk("reset_empty", out_empty, 1);
    chk("reset_busy", busy, 0);
    chk("reset_last", out_last, 0);
    chk("reset_nbytes", out_nbytes, 0);
    chk("reset_dout", out_dout, 0);
    chk("reset_ovf", overflow_err, 0);
    reset = 1'b0;
    tick();
    auto_pop = 1'b1;

    tname = "plain";
    set_cfg(16'd1, 5'd0, 8'd255);
    expect_word(32'h07FF0005, 3'd4, 1'b0);
    send(5, 0); send(-3, 0); send(300, 0); send(7, 0);
    drain(1);

    tname = "scaled_done";
    set_cfg(16'd3, 5'd2, 8'd255);
    expect_word(32'h00000004, 3'd2, 1'b1);
    send(5, 0); send(-5, 0); send_done();
    drain(1);

    tname = "shift31";
    set_cfg(16'd1, 5'd31, 8'd255);
    expect_word(32'h00000001, 3'd2, 1'b1);
    send(32'sh40000000, 0); send(32'sh3FFFFFFF, 0); send_done();
    drain(1);

    tname = "round_half";
    set_cfg(16'd1, 5'd1, 8'd255);
    expect_word(32'h03000102, 3'd4, 1'b0);
    send(3, 0); send(1, 0); send(-1, 0); send(5, 0);
    drain(1);

    tname = "max_mult";
    set_cfg(16'hFFFF, 5'd8, 8'd200);
    expect_word(32'h0000C8C8, 3'd4, 1'b0);
    send(1, 0); send(2, 0); send(-1, 0); send(0, 0);
    drain(1);

    tname = "relu6_full_done";
    set_cfg(16'd1, 5'd0, 8'd6);
    expect_word(32'h06060206, 3'd4, 1'b1);
    send(100, 0); send(2, 0); send(6, 0); send(7, 1);
    drain(1);

    tname = "cfg_busy";
    set_cfg(16'd1, 5'd0, 8'd255);
    expect_word(32'h0000140A, 3'd2, 1'b1);
    send(10, 0);
    chk("cfg_busy_flag", busy, 1);
    cfg_valid = 1'b1; cfg_mult = 16'd2;
    send(20, 0);
    cfg_valid = 1'b0;
    send_done();
    drain(1);

    tname = "empty_done";
    expect_word(32'h00000000, 3'd0, 1'b1);
    send_done();
    drain(1);
    chk("empty_done_busy", busy, 0);

    tname = "backpressure";
    set_cfg(16'd1, 5'd0, 8'd255);
    auto_pop = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 32; i++) begin
      if (out_accepting_values) begin
        n_acc++;
        result = n_acc; resultValid = 1'b1;
      end else begin
        resultValid = 1'b0;
      end
      tick();
    end
    resultValid = 1'b0;
    chk("bp_accept_low", out_accepting_values, 0);
    chk("bp_accepted", n_acc, 11);
    chk("bp_ovf_before", overflow_err, 0);
    result = 99; resultValid = 1'b1;
    tick();
    resultValid = 1'b0;
    chk("bp_ovf_set", overflow_err, 1);
    expect_word(32'h04030201, 3'd4, 1'b0);
    expect_word(32'h08070605, 3'd4, 1'b0);
    auto_pop = 1'b1;
    drain(0);
    tick(); tick();
    chk("bp_two_words_only", out_empty, 1);
    chk("bp_accept_back", out_accepting_values, 1);
    chk("bp_pending_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("bp_rst_busy", busy, 0);
    chk("bp_rst_ovf", overflow_err, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("bp_rst_no_word", out_empty, 1);

    tname = "midimage_reset";
    auto_pop = 1'b0;
    for (int i = 0; i < 6; i++) send(i + 1, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("mid_word_pushed", out_empty, 0);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_empty", out_empty, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dout", out_dout, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_no_word_after", out_empty, 1);
    chk("mid_idle_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
